// File: rtl/counter_ctrl.sv
// counter_ctrl: turns debounced button levels into counter enable/clear/load/direction controls.
// Step auto-repeat (PRESS -> REPEAT with timer) is built only when AUTO_REPEAT_EN is defined.
module counter_ctrl #(
  parameter int unsigned HOLD_CYCLES   = 25_000_000,
  parameter int unsigned REPEAT_CYCLES = 5_000_000,
  parameter logic [3:0]  PRESET        = 4'hA,
  parameter int unsigned TW            = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_step,
  input  logic       btn_clr,
  input  logic       btn_dir,
  input  logic       btn_load,
  output logic       cnt_ce,
  output logic       cnt_up,
  output logic       cnt_clr,
  output logic       cnt_load,
  output logic [3:0] cnt_di,
  output logic       repeating
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRESS  = 2'd1,
    REPEAT = 2'd2
  } state_t;

  state_t state, state_d;
  logic   step_q, clr_q, dir_q, load_q;
  logic   rise_step, rise_clr, rise_dir, rise_load;
  logic   step_ok;
  logic   hold_done, rep_done;
  logic   ce_d, clr_d, load_d, up_d, repeating_d;

  assign rise_step = btn_step & ~step_q;
  assign rise_clr  = btn_clr  & ~clr_q;
  assign rise_dir  = btn_dir  & ~dir_q;
  assign rise_load = btn_load & ~load_q;

  // Step activity is only honoured when neither clear nor load takes precedence
  assign step_ok = ~btn_clr & ~rise_load;

`ifdef AUTO_REPEAT_EN
  logic [TW-1:0] timer, timer_d;

  assign hold_done = (timer == TW'(HOLD_CYCLES - 1));
  assign rep_done  = (timer == TW'(REPEAT_CYCLES - 1));

  always_comb begin
    timer_d = timer;
    if (step_ok) begin
      if (state == IDLE && rise_step)
        timer_d = '0;
      else if (state == PRESS && btn_step)
        timer_d = hold_done ? '0 : timer + TW'(1);
      else if (state == REPEAT && btn_step)
        timer_d = rep_done ? '0 : timer + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) timer <= '0;
    else     timer <= timer_d;
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{HOLD_CYCLES, REPEAT_CYCLES, TW};
  assign hold_done  = 1'b0;
  assign rep_done   = 1'b0;
`endif

  // State and previous-level registers
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
    step_q <= btn_step;
    clr_q  <= btn_clr;
    dir_q  <= btn_dir;
    load_q <= btn_load;
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    if (!step_ok) begin
      state_d = IDLE;
    end else begin
      case (state)
        IDLE:    if (rise_step) state_d = PRESS;
        PRESS:   if (!btn_step) state_d = IDLE;
                 else if (hold_done) state_d = REPEAT;
        REPEAT:  if (!btn_step) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output logic, registered below
  always_comb begin
    ce_d = step_ok && ((state == IDLE   && rise_step) ||
                       (state == PRESS  && btn_step && hold_done) ||
                       (state == REPEAT && btn_step && rep_done));
    clr_d  = rise_clr;
    load_d = rise_load & ~btn_clr;
    up_d   = cnt_up ^ rise_dir;
`ifdef AUTO_REPEAT_EN
    repeating_d = (state_d == REPEAT);
`else
    repeating_d = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    cnt_di <= PRESET;
    if (rst) begin
      cnt_ce    <= 1'b0;
      cnt_clr   <= 1'b0;
      cnt_load  <= 1'b0;
      cnt_up    <= 1'b1;
      repeating <= 1'b0;
    end else begin
      cnt_ce    <= ce_d;
      cnt_clr   <= clr_d;
      cnt_load  <= load_d;
      cnt_up    <= up_d;
      repeating <= repeating_d;
    end
  end

endmodule

// File: tb/tb_counter_ctrl.sv
// tb_counter_ctrl: scoreboard bench for counter_ctrl with HOLD_CYCLES=8, REPEAT_CYCLES=3.
// Expected pulse cycles are queued per scenario; outputs are sampled on the falling edge.
`timescale 1ns/1ps
module tb_counter_ctrl;

  localparam int HOLD = 8;
  localparam int REP  = 3;
`ifdef AUTO_REPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, btn_step, btn_clr, btn_dir, btn_load;
  logic       cnt_ce, cnt_up, cnt_clr, cnt_load, repeating;
  logic [3:0] cnt_di;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int ce_q[$], clr_q[$], load_q[$];
  int exp_ce, exp_clr, exp_load;
  bit mon_en = 1'b0;

  counter_ctrl #(
    .HOLD_CYCLES  (HOLD),
    .REPEAT_CYCLES(REP),
    .PRESET       (4'hA),
    .TW           (32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_step (btn_step),
    .btn_clr  (btn_clr),
    .btn_dir  (btn_dir),
    .btn_load (btn_load),
    .cnt_ce   (cnt_ce),
    .cnt_up   (cnt_up),
    .cnt_clr  (cnt_clr),
    .cnt_load (cnt_load),
    .cnt_di   (cnt_di),
    .repeating(repeating)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse scoreboard: every observed pulse must match the head of its queue
  always @(negedge clk) begin
    if (mon_en) begin
      if (cnt_ce === 1'b1) begin
        n_cmp++;
        if (ce_q.size() == 0) begin
          n_fail++;
          $display("FAIL ce_pulse: got pulse at cycle %0d, required none", cyc);
        end else begin
          exp_ce = ce_q.pop_front();
          if (cyc !== exp_ce) begin
            n_fail++;
            $display("FAIL ce_pulse: got pulse at cycle %0d, required cycle %0d", cyc, exp_ce);
          end
        end
      end
      if (cnt_clr === 1'b1) begin
        n_cmp++;
        if (clr_q.size() == 0) begin
          n_fail++;
          $display("FAIL clr_pulse: got pulse at cycle %0d, required none", cyc);
        end else begin
          exp_clr = clr_q.pop_front();
          if (cyc !== exp_clr) begin
            n_fail++;
            $display("FAIL clr_pulse: got pulse at cycle %0d, required cycle %0d", cyc, exp_clr);
          end
        end
      end
      if (cnt_load === 1'b1) begin
        n_cmp++;
        if (load_q.size() == 0) begin
          n_fail++;
          $display("FAIL load_pulse: got pulse at cycle %0d, required none", cyc);
        end else begin
          exp_load = load_q.pop_front();
          if (cyc !== exp_load) begin
            n_fail++;
            $display("FAIL load_pulse: got pulse at cycle %0d, required cycle %0d", cyc, exp_load);
          end
        end
        n_cmp++;
        if (cnt_di !== 4'hA) begin
          n_fail++;
          $display("FAIL load_data: got %h, required a", cnt_di);
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; btn_step = 1'b0; btn_clr = 1'b0; btn_dir = 1'b0; btn_load = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp += 6;
    if (cnt_up !== 1'b1)    begin n_fail++; $display("FAIL reset_up: got %b, required 1", cnt_up); end
    if (cnt_di !== 4'hA)    begin n_fail++; $display("FAIL reset_di: got %h, required a", cnt_di); end
    if (cnt_ce !== 1'b0)    begin n_fail++; $display("FAIL reset_ce: got %b, required 0", cnt_ce); end
    if (cnt_clr !== 1'b0)   begin n_fail++; $display("FAIL reset_clr: got %b, required 0", cnt_clr); end
    if (cnt_load !== 1'b0)  begin n_fail++; $display("FAIL reset_load: got %b, required 0", cnt_load); end
    if (repeating !== 1'b0) begin n_fail++; $display("FAIL reset_rep: got %b, required 0", repeating); end
    rst = 1'b0;
    mon_en = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_queues_empty(input string name);
    repeat (6) @(negedge clk);
    n_cmp += 3;
    if (ce_q.size() !== 0)   begin n_fail++; $display("FAIL %s_ce_missing: got %0d left, required 0", name, ce_q.size()); ce_q.delete(); end
    if (clr_q.size() !== 0)  begin n_fail++; $display("FAIL %s_clr_missing: got %0d left, required 0", name, clr_q.size()); clr_q.delete(); end
    if (load_q.size() !== 0) begin n_fail++; $display("FAIL %s_load_missing: got %0d left, required 0", name, load_q.size()); load_q.delete(); end
  endtask

  task automatic test_single_press();
    int e;
    @(negedge clk); e = cyc + 1; btn_step = 1'b1;
    ce_q.push_back(e);
    repeat (4) @(negedge clk);
    btn_step = 1'b0;
    test_queues_empty("single");
  endtask

  task automatic test_auto_repeat();
    int e;
    logic exp_r;
    @(negedge clk); e = cyc + 1; btn_step = 1'b1;
    ce_q.push_back(e);
    if (AUTO) begin
      ce_q.push_back(e + HOLD);
      for (int k = e + HOLD + REP; k < e + 20; k += REP) ce_q.push_back(k);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      exp_r = AUTO && (i >= HOLD);
      n_cmp++;
      if (repeating !== exp_r) begin
        n_fail++;
        $display("FAIL repeat_flag: cycle %0d got %b, required %b", cyc, repeating, exp_r);
      end
    end
    btn_step = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (repeating !== 1'b0) begin
      n_fail++;
      $display("FAIL repeat_release: got %b, required 0", repeating);
    end
    test_queues_empty("repeat");
  endtask

  task automatic test_clr_priority();
    int e;
    @(negedge clk); e = cyc + 1; btn_clr = 1'b1; btn_step = 1'b1;
    clr_q.push_back(e);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n_cmp++;
      if (repeating !== 1'b0) begin
        n_fail++;
        $display("FAIL clr_idle: cycle %0d got repeating %b, required 0", cyc, repeating);
      end
    end
    btn_clr = 1'b0; btn_step = 1'b0;
    test_queues_empty("clr");
  endtask

  task automatic test_dir();
    @(negedge clk);
    n_cmp++;
    if (cnt_up !== 1'b1) begin n_fail++; $display("FAIL dir_init: got %b, required 1", cnt_up); end
    btn_dir = 1'b1;
    @(negedge clk);
    btn_dir = 1'b0;
    n_cmp++;
    if (cnt_up !== 1'b0) begin n_fail++; $display("FAIL dir_first: got %b, required 0", cnt_up); end
    repeat (4) @(negedge clk);
    n_cmp++;
    if (cnt_up !== 1'b0) begin n_fail++; $display("FAIL dir_hold: got %b, required 0", cnt_up); end
    btn_dir = 1'b1;
    @(negedge clk);
    btn_dir = 1'b0;
    n_cmp++;
    if (cnt_up !== 1'b1) begin n_fail++; $display("FAIL dir_second: got %b, required 1", cnt_up); end
    test_queues_empty("dir");
  endtask

  task automatic test_load_in_repeat();
    int e;
    logic exp_r;
    @(negedge clk); e = cyc + 1; btn_step = 1'b1;
    ce_q.push_back(e);
    if (AUTO) ce_q.push_back(e + HOLD);
    load_q.push_back(e + 10);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 9)  btn_load = 1'b1;
      if (i == 10) btn_load = 1'b0;
      exp_r = AUTO && (i >= HOLD) && (i < 10);
      n_cmp++;
      if (repeating !== exp_r) begin
        n_fail++;
        $display("FAIL load_repeat_flag: cycle %0d got %b, required %b", cyc, repeating, exp_r);
      end
    end
    btn_step = 1'b0;
    test_queues_empty("load_rep");
    // A fresh press after the load must step again
    @(negedge clk); e = cyc + 1; btn_step = 1'b1;
    ce_q.push_back(e);
    repeat (2) @(negedge clk);
    btn_step = 1'b0;
    test_queues_empty("repress");
  endtask

  task automatic test_back_to_back();
    int e;
    @(negedge clk); e = cyc + 1; btn_step = 1'b1; btn_load = 1'b1;
    load_q.push_back(e);
    @(negedge clk);
    btn_load = 1'b0;
    repeat (12) @(negedge clk);
    btn_step = 1'b0;
    test_queues_empty("load_step");
  endtask

  task automatic test_reset_abort();
    int e;
    logic exp_r;
    @(negedge clk); e = cyc + 1; btn_step = 1'b1;
    ce_q.push_back(e);
    if (AUTO) ce_q.push_back(e + HOLD);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 9)  rst = 1'b1;
      if (i == 10) rst = 1'b0;
      exp_r = AUTO && (i >= HOLD) && (i < 10);
      n_cmp++;
      if (repeating !== exp_r) begin
        n_fail++;
        $display("FAIL rst_abort_flag: cycle %0d got %b, required %b", cyc, repeating, exp_r);
      end
    end
    btn_step = 1'b0;
    test_queues_empty("rst_abort");
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_auto_repeat();
    test_clr_priority();
    test_dir();
    test_load_in_repeat();
    test_back_to_back();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
